// File: rtl/data_sram_slave.sv
// Single-port data RAM responder for the data cache's sram-like memory port.
// Latency: data_ok arrives LATENCY cycles after address acceptance; one transaction in flight.
// Backpressure: addr_ok only in IDLE and only when stall is low; req is ignored while busy.
module data_sram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_data_req,
    input  logic        mem_data_wr,
    input  logic [1:0]  mem_data_size,
    input  logic [31:0] mem_data_addr,
    input  logic [31:0] mem_data_wdata,
    input  logic        stall,
    output logic [31:0] mem_data_rdata,
    output logic        mem_data_addr_ok,
    output logic        mem_data_data_ok,
    output logic        misalign
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_cnt;
    logic                    r_wr;
    logic [1:0]              r_size;
    logic [1:0]              r_off;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_addr_ok;
    logic                    w_done;
    logic                    w_accept;
    logic [3:0]              w_mask;
    logic [31:0]             w_mask32;
    logic                    w_misalign;
    logic [31:0]             w_rd_word;
    logic                    w_unused;

    // Upper address bits alias onto the same words by design.
    assign w_unused = &{1'b0, mem_data_addr[31:ADDR_WIDTH+2]};

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_addr_ok    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_ok = mem_data_req & ~stall;
                if (w_addr_ok) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Acceptance only counts outside reset so nothing latches while rst is low.
    assign w_accept = rst & w_addr_ok;

    // Latency counter: loaded on acceptance, counts down to the data_ok cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(LATENCY - 1);
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture the request at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_idx   <= '0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_wr    <= mem_data_wr;
            r_size  <= mem_data_size;
            r_off   <= mem_data_addr[1:0];
            r_idx   <= mem_data_addr[ADDR_WIDTH+1:2];
            r_wdata <= mem_data_wdata;
        end
    end

    // Byte-lane mask from latched size/offset; size 11 behaves as a word.
    always_comb begin
        w_mask = 4'b1111;
        case (r_size)
            2'b00: w_mask = 4'b0001 << r_off;
            2'b01: w_mask = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_mask32 = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};

    assign w_misalign = ((r_size == 2'b01) & r_off[0]) |
                        (r_size[1] & (r_off != 2'b00));

    // RAM write port: commits at the edge closing data_ok, skipped if reset is sampled there.
    always_ff @(posedge clk) begin
        if (rst && w_done && r_wr) begin
            r_mem[r_idx] <= (r_mem[r_idx] & ~w_mask32) | (r_wdata & w_mask32);
        end
    end

    // Read is combinational; a write shows the pre-write word during its data_ok.
    assign w_rd_word = r_mem[r_idx];

    assign mem_data_addr_ok = w_accept;
    assign mem_data_data_ok = rst & w_done;
    assign misalign         = rst & w_done & w_misalign;
    assign mem_data_rdata   = (rst & w_done) ? w_rd_word : 32'h0;

endmodule
